// File: rtl/fetch_seq.sv
// fetch_seq: instruction-fetch sequencer. Owns the PC, runs the imem
// req/ack handshake and presents fetched words to decode with valid/ready.
// Honours one branch delay slot, and flushes to the exception vector or EPC.
module fetch_seq #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic        if_adel,
   input  logic        br_valid,
   input  logic [31:0] br_target,
   input  logic        exc_req,
   input  logic        eret_req,
   input  logic [31:0] epc,
   output logic        flushing
);

   typedef enum logic [1:0] {BOOT, REQ, OUT, ADEL} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] pend_tgt_q, pend_tgt_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] ifpc_q, ifpc_d;
   logic        pend_q, pend_d;
   logic        drop_q, drop_d;
   logic        req_q, req_d;
   logic        valid_q, valid_d;
   logic        adel_q, adel_d;

   logic        flush;
   logic [31:0] flush_tgt;
   logic        accept;
   logic        go;
   logic [31:0] go_pc;

   assign flush     = exc_req | eret_req;
   assign flush_tgt = exc_req ? EXC_VEC : epc;
   assign accept    = valid_q & if_ready;

   // Next-state and next-PC selection; 'go' restarts fetching at go_pc.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pend_tgt_d = pend_tgt_q;
      instr_d    = instr_q;
      ifpc_d     = ifpc_q;
      pend_d     = pend_q;
      drop_d     = drop_q;
      req_d      = req_q;
      valid_d    = valid_q;
      adel_d     = adel_q;
      go         = 1'b0;
      go_pc      = pc_q;

      // A branch resolved outside an accept cycle is remembered until the
      // delay-slot instruction is accepted; the last one wins.
      if (flush) begin
         pend_d = 1'b0;
      end else if (br_valid && !accept) begin
         pend_d     = 1'b1;
         pend_tgt_d = br_target;
      end

      unique case (state_q)
         BOOT: begin
            go    = 1'b1;
            go_pc = flush ? flush_tgt : pc_q;
         end
         REQ: begin
            if (req_q && imem_ack) begin
               req_d = 1'b0;
               if (flush || drop_q) begin
                  drop_d = 1'b0;
                  go     = 1'b1;
                  go_pc  = flush ? flush_tgt : pc_q;
               end else begin
                  state_d = OUT;
                  valid_d = 1'b1;
                  adel_d  = 1'b0;
                  instr_d = imem_rdata;
                  ifpc_d  = pc_q;
               end
            end else if (req_q) begin
               // Transaction outstanding: retarget PC now, discard its data later.
               if (flush) begin
                  drop_d = 1'b1;
                  pc_d   = flush_tgt;
               end
            end else if (flush) begin
               go    = 1'b1;
               go_pc = flush_tgt;
            end else begin
               req_d = 1'b1;
            end
         end
         OUT, ADEL: begin
            if (flush) begin
               go    = 1'b1;
               go_pc = flush_tgt;
            end else if (accept) begin
               go     = 1'b1;
               go_pc  = br_valid ? br_target : (pend_q ? pend_tgt_q : pc_q + 32'd4);
               pend_d = 1'b0;
            end else if (!valid_q) begin
               valid_d = 1'b1;
               adel_d  = 1'b1;
               instr_d = '0;
               ifpc_d  = pc_q;
            end
         end
      endcase

      if (go) begin
         pc_d    = go_pc;
         valid_d = 1'b0;
         adel_d  = 1'b0;
         req_d   = 1'b0;
         state_d = (go_pc[1:0] != 2'b00) ? ADEL : REQ;
      end

      // imem_addr tracks PC except while a request awaits its ack.
      addr_d = (req_q && !imem_ack) ? addr_q : pc_d;
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= BOOT;
         pc_q       <= RESET_PC;
         addr_q     <= RESET_PC;
         pend_tgt_q <= '0;
         instr_q    <= '0;
         ifpc_q     <= '0;
         pend_q     <= 1'b0;
         drop_q     <= 1'b0;
         req_q      <= 1'b0;
         valid_q    <= 1'b0;
         adel_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         addr_q     <= addr_d;
         pend_tgt_q <= pend_tgt_d;
         instr_q    <= instr_d;
         ifpc_q     <= ifpc_d;
         pend_q     <= pend_d;
         drop_q     <= drop_d;
         req_q      <= req_d;
         valid_q    <= valid_d;
         adel_q     <= adel_d;
      end
   end

   assign imem_req  = req_q;
   assign imem_addr = addr_q;
   assign if_valid  = valid_q;
   assign if_instr  = instr_q;
   assign if_pc     = ifpc_q;
   assign if_adel   = adel_q;
   assign flushing  = drop_q;

endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: directed bench for fetch_seq with a latency-programmable
// instruction memory and scoreboards of expected fetch addresses and
// expected accepted instructions.
module tb_fetch_seq;

   logic        clk, rst_n;
   logic        imem_req, imem_ack;
   logic [31:0] imem_addr, imem_rdata;
   logic        if_valid, if_ready, if_adel;
   logic [31:0] if_instr, if_pc;
   logic        br_valid, exc_req, eret_req, flushing;
   logic [31:0] br_target, epc;

   typedef struct packed {
      logic        adel;
      logic [31:0] pc;
      logic [31:0] instr;
   } out_t;

   logic [31:0] exp_addr_q[$];
   out_t        exp_out_q[$];

   int          n_tests, n_fail, n_acc;
   int          mem_lat, mem_cnt;
   bit          mem_busy, mem_stale, mem_bad, ack_prev;
   logic [31:0] mem_addr_r, mem_data;

   fetch_seq #(
      .RESET_PC(32'h0000_3000),
      .EXC_VEC (32'h0000_4180)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .imem_req  (imem_req),
      .imem_addr (imem_addr),
      .imem_ack  (imem_ack),
      .imem_rdata(imem_rdata),
      .if_valid  (if_valid),
      .if_ready  (if_ready),
      .if_instr  (if_instr),
      .if_pc     (if_pc),
      .if_adel   (if_adel),
      .br_valid  (br_valid),
      .br_target (br_target),
      .exc_req   (exc_req),
      .eret_req  (eret_req),
      .epc       (epc),
      .flushing  (flushing)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something unforeseen stalls the run.
   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] mword(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, expv);
      end
   endtask

   task automatic push_out(input logic adel, input logic [31:0] pc, input logic [31:0] instr);
      out_t o;
      o.adel  = adel;
      o.pc    = pc;
      o.instr = instr;
      exp_out_q.push_back(o);
   endtask

   // One clock cycle: memory model and monitors run at the negedge, then
   // the clock advances to the next negedge and pulse inputs drop.
   task automatic cyc();
      out_t o;
      if (!rst_n && mem_busy) mem_stale = 1'b1;
      if (ack_prev) begin
         chk("req_low_after_ack", {31'd0, imem_req}, 32'd0);
         imem_ack = 1'b0;
         ack_prev = 1'b0;
      end
      if (mem_busy) begin
         if (!mem_stale) begin
            chk("req_held", {31'd0, imem_req}, 32'd1);
            chk("addr_held", imem_addr, mem_addr_r);
         end
         mem_cnt--;
      end else if (imem_req && rst_n) begin
         n_tests++;
         assert (exp_addr_q.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_req: observed 0x%h expected none", imem_addr);
         end
         if (exp_addr_q.size() != 0) chk("req_addr", imem_addr, exp_addr_q.pop_front());
         mem_busy   = 1'b1;
         mem_stale  = 1'b0;
         mem_cnt    = mem_lat;
         mem_addr_r = imem_addr;
         mem_data   = mem_bad ? 32'hDEAD_BEEF : mword(imem_addr);
         mem_bad    = 1'b0;
      end
      if (mem_busy && mem_cnt == 0) begin
         imem_ack   = 1'b1;
         imem_rdata = mem_data;
         mem_busy   = 1'b0;
         ack_prev   = 1'b1;
      end
      if (rst_n && if_valid && if_ready) begin
         n_acc++;
         n_tests++;
         assert (exp_out_q.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_accept: observed pc 0x%h expected none", if_pc);
         end
         if (exp_out_q.size() != 0) begin
            o = exp_out_q.pop_front();
            chk("acc_pc", if_pc, o.pc);
            chk("acc_instr", if_instr, o.instr);
            chk("acc_adel", {31'd0, if_adel}, {31'd0, o.adel});
         end
      end
      @(posedge clk);
      @(negedge clk);
      br_valid = 1'b0;
      exc_req  = 1'b0;
      eret_req = 1'b0;
   endtask

   task automatic run_accepts(input int n);
      int target;
      int budget;
      target   = n_acc + n;
      budget   = 0;
      if_ready = 1'b1;
      while (n_acc < target && budget < 60 * n) begin
         cyc();
         budget++;
      end
      if_ready = 1'b0;
      n_tests++;
      assert (n_acc >= target) else begin
         n_fail++;
         $error("FAIL accept_timeout: observed %0d expected %0d", n_acc, target);
      end
   endtask

   task automatic wait_valid(input string tag);
      int b;
      b = 0;
      while (!if_valid && b < 30) begin
         cyc();
         b++;
      end
      chk(tag, {31'd0, if_valid}, 32'd1);
   endtask

   task automatic wait_req(input string tag);
      int b;
      b = 0;
      while (!imem_req && b < 30) begin
         cyc();
         b++;
      end
      chk(tag, {31'd0, imem_req}, 32'd1);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_addr"}, imem_addr, 32'h0000_3000);
      chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
      chk({tag, "_valid"}, {31'd0, if_valid}, 32'd0);
      chk({tag, "_adel"}, {31'd0, if_adel}, 32'd0);
      chk({tag, "_flushing"}, {31'd0, flushing}, 32'd0);
      chk({tag, "_instr"}, if_instr, 32'd0);
      chk({tag, "_pc"}, if_pc, 32'd0);
   endtask

   // Directed test sequence.
   initial begin
      int b;
      n_tests = 0; n_fail = 0; n_acc = 0;
      mem_lat = 2; mem_cnt = 0;
      mem_busy = 0; mem_stale = 0; mem_bad = 0; ack_prev = 0;
      mem_addr_r = '0; mem_data = '0;
      rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; if_ready = 1'b0;
      br_valid = 1'b0; br_target = '0; exc_req = 1'b0; eret_req = 1'b0; epc = '0;

      repeat (2) @(negedge clk);
      chk_reset("rst");
      rst_n = 1'b1;

      // Sequential fetch, ack two cycles after each request.
      exp_addr_q.push_back(32'h3000);
      exp_addr_q.push_back(32'h3004);
      exp_addr_q.push_back(32'h3008);
      exp_addr_q.push_back(32'h300C);
      push_out(1'b0, 32'h3000, mword(32'h3000));
      push_out(1'b0, 32'h3004, mword(32'h3004));
      push_out(1'b0, 32'h3008, mword(32'h3008));
      run_accepts(3);
      push_out(1'b0, 32'h300C, mword(32'h300C));

      // Branch resolved while the delay slot is in REQ.
      exp_addr_q.push_back(32'h3010);
      run_accepts(1);
      br_valid = 1'b1; br_target = 32'h3100;
      cyc();
      exp_addr_q.push_back(32'h3100);
      exp_addr_q.push_back(32'h3104);
      push_out(1'b0, 32'h3010, mword(32'h3010));
      push_out(1'b0, 32'h3100, mword(32'h3100));
      run_accepts(2);
      push_out(1'b0, 32'h3104, mword(32'h3104));

      // Branch coincident with the accept of its delay slot.
      wait_valid("valid_3104");
      exp_addr_q.push_back(32'h3200);
      if_ready = 1'b1; br_valid = 1'b1; br_target = 32'h3200;
      cyc();
      if_ready = 1'b0;
      // Two branches while the slot is in REQ: the later target wins.
      br_valid = 1'b1; br_target = 32'h3300;
      cyc();
      br_valid = 1'b1; br_target = 32'h3400;
      cyc();
      exp_addr_q.push_back(32'h3400);
      exp_addr_q.push_back(32'h3404);
      push_out(1'b0, 32'h3200, mword(32'h3200));
      push_out(1'b0, 32'h3400, mword(32'h3400));
      run_accepts(2);
      push_out(1'b0, 32'h3404, mword(32'h3404));

      // Decode stall: outputs hold, no requests.
      wait_valid("valid_3404");
      for (int i = 0; i < 5; i++) begin
         chk("stall_pc", if_pc, 32'h3404);
         chk("stall_instr", if_instr, mword(32'h3404));
         chk("stall_req", {31'd0, imem_req}, 32'd0);
         cyc();
      end
      exp_addr_q.push_back(32'h3408);
      run_accepts(1);
      push_out(1'b0, 32'h3408, mword(32'h3408));

      // Exception while a request is outstanding: data must be dropped.
      exp_addr_q.push_back(32'h340C);
      exp_addr_q.push_back(32'h4180);
      run_accepts(1);
      mem_lat = 3; mem_bad = 1'b1;
      wait_req("req_340c");
      exc_req = 1'b1;
      cyc();
      chk("flush_valid_low", {31'd0, if_valid}, 32'd0);
      b = 0;
      while (mem_busy && b < 10) begin
         chk("flushing_hold", {31'd0, flushing}, 32'd1);
         cyc();
         b++;
      end
      chk("flushing_clear", {31'd0, flushing}, 32'd0);
      wait_valid("valid_4180");
      chk("exc_pc", if_pc, 32'h4180);
      chk("exc_instr", if_instr, mword(32'h4180));

      // exc_req and eret_req together from OUT: exception vector wins.
      mem_lat = 1;
      exp_addr_q.push_back(32'h4180);
      exc_req = 1'b1; eret_req = 1'b1; epc = 32'h5000;
      cyc();
      chk("both_valid_low", {31'd0, if_valid}, 32'd0);
      wait_valid("valid_both");
      chk("both_pc", if_pc, 32'h4180);

      // eret to a misaligned EPC: address-error slot, no memory access.
      eret_req = 1'b1; epc = 32'h3012;
      cyc();
      chk("eret_valid_low", {31'd0, if_valid}, 32'd0);
      wait_valid("valid_adel");
      chk("adel_flag", {31'd0, if_adel}, 32'd1);
      chk("adel_pc", if_pc, 32'h3012);
      chk("adel_instr", if_instr, 32'd0);
      chk("adel_req", {31'd0, imem_req}, 32'd0);
      push_out(1'b1, 32'h3012, 32'd0);
      run_accepts(1);
      wait_valid("valid_adel2");
      chk("adel2_pc", if_pc, 32'h3016);
      chk("adel2_flag", {31'd0, if_adel}, 32'd1);
      exp_addr_q.push_back(32'h4180);
      exc_req = 1'b1;
      cyc();
      wait_valid("valid_from_adel");
      chk("from_adel_pc", if_pc, 32'h4180);
      chk("from_adel_flag", {31'd0, if_adel}, 32'd0);

      // Reset mid-REQ with a stale ack landing during BOOT.
      push_out(1'b0, 32'h4180, mword(32'h4180));
      exp_addr_q.push_back(32'h4184);
      run_accepts(1);
      mem_lat = 3; mem_bad = 1'b1;
      wait_req("req_4184");
      cyc();
      rst_n = 1'b0;
      cyc();
      chk_reset("midrst");
      cyc();
      rst_n = 1'b1;
      exp_addr_q.push_back(32'h3000);
      exp_addr_q.push_back(32'h3004);
      push_out(1'b0, 32'h3000, mword(32'h3000));
      mem_lat = 1;
      cyc();
      run_accepts(1);
      repeat (6) cyc();
      chk("addr_q_drained", exp_addr_q.size(), 32'd0);
      chk("out_q_drained", exp_out_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
